// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the program loader and the pipeline's instruction
//   memory: memory geometry, the loader FSM state encoding and a helper that
//   limits a requested word count to the memory depth.
package prog_loader_pkg;

  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_AW    = 10;
  localparam int COUNT_W    = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;

  // Requests larger than the memory are trimmed so the write address can
  // never run past the last word.
  function automatic logic [COUNT_W-1:0] clampCount(input logic [COUNT_W-1:0] req);
    if (req > COUNT_W'(IMEM_DEPTH))
      return COUNT_W'(IMEM_DEPTH);
    return req;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Bundles the loader's control, byte-stream and memory-write signals.
//   slave  : the loader itself (takes start/bytes, drives memory + status)
//   master : whoever requests loads and supplies bytes
//   Signals:
//     start, word_count      load request and number of words (0..1024)
//     byte_in, byte_valid    byte stream in; byte_ready is the loader's accept
//     mem_we/addr/wdata      instruction-memory write port
//     cpu_hold, busy, done   pipeline hold, activity, completion pulse
//     checksum               mod-2^32 sum of words written by the last load
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic               start;
  logic [COUNT_W-1:0] word_count;
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               mem_we;
  logic [IMEM_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic               cpu_hold;
  logic               busy;
  logic               done;
  logic [31:0]        checksum;

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, checksum
  );

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, checksum
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer
//   Assembles four accepted bytes into one 32-bit word.
//   Ports:
//     clk, rst          clock, async active-high reset
//     clear_i           restart at byte 0 with an empty word
//     push_i            a byte is accepted this cycle
//     byte_i            the byte being accepted
//     word_o            current word with byte_i merged into its lane; this is
//                       the complete word in the cycle word_complete_o is high
//     word_complete_o   push of the fourth byte of a word
module byte_packer #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [1:0]  index_q, index_d;
  logic [31:0] word_q,  word_d;
  logic [1:0]  lane;

  // Big-endian puts the first byte in the top lane, little-endian in lane 0.
  assign lane = BIG_ENDIAN ? (2'd3 - index_q) : index_q;

  // Merge the incoming byte into its lane; the 2-bit index wraps to 0 after
  // the fourth byte so the next word starts cleanly.
  always_comb begin
    word_d  = word_q;
    index_d = index_q;
    word_d[{lane, 3'b000} +: 8] = byte_i;
    if (clear_i)
      index_d = 2'd0;
    else if (push_i)
      index_d = index_q + 2'd1;
  end

  // Index and partial word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= 2'd0;
      word_q  <= 32'd0;
    end else if (clear_i) begin
      index_q <= 2'd0;
      word_q  <= 32'd0;
    end else if (push_i) begin
      index_q <= index_d;
      word_q  <= word_d;
    end
  end

  assign word_o          = word_d;
  assign word_complete_o = push_i && (index_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Streams a program, byte by byte, into instruction memory while holding
//   the CPU pipeline. Each four accepted bytes form one word which is written
//   in a single WRITE cycle; a running checksum of written words is kept.
//   Ports:
//     clk1   sole clock, rising edge
//     rst    asynchronous active-high reset
//     bus    prog_loader_if.slave (request, byte stream, memory write, status)
//   Parameter BIG_ENDIAN: 1 = first byte of a word lands in [31:24].
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic           clk1,
  input  logic           rst,
  prog_loader_if.slave   bus
);

  loader_state_t      state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [IMEM_AW-1:0] wordAddr_q, wordAddr_d;
  logic [IMEM_AW-1:0] memAddr_q, memAddr_d;
  logic [31:0]        memWdata_q, memWdata_d;
  logic [31:0]        checksum_q, checksum_d;

  logic        transfer;
  logic        packClear;
  logic [31:0] packedWord;
  logic        wordComplete;

  assign transfer  = (state_q == ST_COLLECT) && bus.byte_valid;
  assign packClear = (state_q == ST_IDLE) && bus.start;

  byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk             (clk1),
    .rst             (rst),
    .clear_i         (packClear),
    .push_i          (transfer),
    .byte_i          (bus.byte_in),
    .word_o          (packedWord),
    .word_complete_o (wordComplete)
  );

  // Next-state logic. wordAddr is the address of the word being collected;
  // mem_addr/mem_wdata are only reloaded when a word completes, so they hold
  // steady between writes.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wordAddr_d = wordAddr_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    checksum_d = checksum_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d    = clampCount(bus.word_count);
          wordAddr_d = '0;
          memAddr_d  = '0;
          checksum_d = 32'd0;
          state_d    = (bus.word_count == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (wordComplete) begin
          memWdata_d = packedWord;
          memAddr_d  = wordAddr_q;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        checksum_d = checksum_q + memWdata_q;
        if (COUNT_W'(wordAddr_q) == count_q - COUNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          wordAddr_d = wordAddr_q + IMEM_AW'(1);
          state_d    = ST_COLLECT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      wordAddr_q <= '0;
      memAddr_q  <= '0;
      memWdata_q <= 32'd0;
      checksum_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wordAddr_q <= wordAddr_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      checksum_q <= checksum_d;
    end
  end

  assign bus.byte_ready = (state_q == ST_COLLECT);
  assign bus.mem_we     = (state_q == ST_WRITE);
  assign bus.cpu_hold   = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_wdata  = memWdata_q;
  assign bus.checksum   = checksum_q;

endmodule
